// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage: funct3 access ops and byte enables.
package mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Lane select and sign/zero extension of a data memory read word.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  addr,
  input  logic [2:0]  op,
  output logic [31:0] value
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sext;

  always_comb begin
    b     = dout[{addr, 3'b000} +: 8];
    h     = addr[1] ? dout[31:16] : dout[15:0];
    sext  = ~op[2];
    value = dout;
    unique case (op[1:0])
      2'b00:   value = {{24{b[7] & sext}}, b};
      2'b01:   value = {{16{h[15] & sext}}, h};
      default: value = dout;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives dm, extracts load data, owns the MEM/WB register.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [2:0]       ex_mem_op,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_store_data,
  input  logic [31:0]      ex_alu_result,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             stall,
  input  logic             flush,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             misalign,
  output logic [31:0]      misalign_addr
);

  logic        is_mem;
  logic        access;
  logic        is_h;
  logic        is_w;
  logic        misalign_c;
  logic        store_done;
  logic [31:0] ld_value;
  logic [31:0] wb_next;
  logic        unused_addr;

  assign unused_addr = ^ex_addr[31:DM_AW+2];

  assign is_mem = ex_mem_read | ex_mem_write;
  assign access = ex_valid & is_mem;
  assign is_w   = ex_mem_op[1];
  assign is_h   = (ex_mem_op[1:0] == 2'b01);

  // Only real memory ops can fault; ALU ops carry arbitrary op bits.
  assign misalign_c = is_mem &
    ((is_h & ex_addr[0]) | (is_w & (|ex_addr[1:0])));

  always_comb begin
    dm_be = BE_NONE;
    if (access & ~misalign_c) begin
      unique case (1'b1)
        is_w:    dm_be = BE_ALL;
        is_h:    dm_be = ex_addr[1] ? BE_HI : BE_LO;
        default: dm_be = BE_B0 << ex_addr[1:0];
      endcase
    end
  end

  assign dm_addr = ex_addr[DM_AW+1:2];
  assign dm_din  = ex_store_data;
  assign dm_we   = ex_valid & ex_mem_write & ~misalign_c
                 & ~flush & ~store_done;

  // Remembers that the stalled store already hit dm.
  always_ff @(posedge clk) begin
    if (!rstn)
      store_done <= 1'b0;
    else if (!stall)
      store_done <= 1'b0;
    else if (dm_we)
      store_done <= 1'b1;
  end

  load_extend u_load_extend (
    .dout  (dm_dout),
    .addr  (ex_addr[1:0]),
    .op    (ex_mem_op),
    .value (ld_value)
  );

  assign wb_next = ex_mem_read ? ld_value : ex_alu_result;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else if (flush) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      misalign     <= 1'b0;
    end else if (stall) begin
      misalign <= 1'b0;
    end else begin
      wb_valid     <= ex_valid;
      wb_reg_write <= ex_valid & ex_reg_write & ~misalign_c;
      wb_rd        <= ex_rd;
      wb_data      <= wb_next;
      misalign     <= ex_valid & misalign_c;
      if (ex_valid & misalign_c)
        misalign_addr <= ex_addr;
    end
  end

endmodule
